// File: rtl/mul_seq_pkg.sv
// Shared types and sizes for the sequential multiplier.
package mul_seq_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Operand/result handshake bundle between the pipeline and the multiplier.
interface mul_seq_if import mul_seq_pkg::*;;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_p;
  logic             busy;

  // Pipeline side: offers operands, consumes the result.
  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_p, busy
  );

endinterface

// File: rtl/mul_seq_fa32.sv
// 32-bit ripple-carry adder; the final carry-out is deliberately dropped so the
// sum wraps modulo 2^32.
module FA32 import mul_seq_pkg::*; (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic carry;

  // Bit-serial carry chain across the word.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add multiplier: one adder step per cycle, low 32 bits of a*b.
module mul_seq import mul_seq_pkg::*; #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] adder_b;
  logic [WIDTH-1:0] adder_sum;
  logic [WIDTH-1:0] mplier_shr;

  // Partial product selection: add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    adder_b    = mplier_q[0] ? mcand_q : '0;
    mplier_shr = mplier_q >> 1;
  end

  FA32 u_fa32 (
    .a   (acc_q),
    .b   (adder_b),
    .sum (adder_sum)
  );

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !bus.flush) begin
          mcand_d  = bus.in_a;
          mplier_d = bus.in_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = (EARLY_EXIT && (bus.in_b == '0)) ? StDone : StRun;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = adder_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shr;
          cnt_d    = cnt_q + 1'b1;
          if ((cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && (mplier_shr == '0))) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.flush || bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake outputs decoded from registered state only (plus flush gating on in_ready).
  always_comb begin
    bus.in_ready  = (state_q == StIdle) && !bus.flush;
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.out_p     = acc_q;
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: latency/product model plus directed vectors.
module tb_mul_seq;

  logic clk;
  logic rst_n;

  mul_seq_if if1 ();
  mul_seq_if if0 ();

  mul_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mul_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Step count of an early-exit multiply: index of the highest set bit of b, plus one.
  function automatic int n_steps(input logic [31:0] b);
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  // Model of the early-exit instance: 0 idle, 1 computing, 2 result waiting.
  int          m_ph;
  int          m_rem;
  logic [31:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 0;
      m_rem  <= 0;
      m_prod <= '0;
    end else begin
      case (m_ph)
        0: if (if1.in_valid && !if1.flush) begin
             m_prod <= if1.in_a * if1.in_b;
             m_rem  <= n_steps(if1.in_b);
             m_ph   <= (n_steps(if1.in_b) == 0) ? 2 : 1;
           end
        1: if (if1.flush) m_ph <= 0;
           else begin
             m_rem <= m_rem - 1;
             if (m_rem == 1) m_ph <= 2;
           end
        default: if (if1.flush || if1.out_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("model_in_ready", 32'(if1.in_ready), 32'((m_ph == 0) && !if1.flush));
    chk("model_out_valid", 32'(if1.out_valid), 32'(m_ph == 2));
    chk("model_busy", 32'(if1.busy), 32'(m_ph != 0));
    if (m_ph == 2) chk("model_out_p", if1.out_p, m_prod);
  end

  task automatic set_in(input bit s, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (s) begin if1.in_valid = v; if1.in_a = a; if1.in_b = b; end
    else   begin if0.in_valid = v; if0.in_a = a; if0.in_b = b; end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) if1.out_ready = v; else if0.out_ready = v;
  endtask

  function automatic logic get_ov(input bit s);
    return s ? if1.out_valid : if0.out_valid;
  endfunction

  function automatic logic get_ir(input bit s);
    return s ? if1.in_ready : if0.in_ready;
  endfunction

  function automatic logic [31:0] get_p(input bit s);
    return s ? if1.out_p : if0.out_p;
  endfunction

  // One operation; entered and left just after a rising edge.
  task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                    input logic [31:0] exp_p, input int exp_lat);
    int lat;
    set_in(s, 1'b1, a, b);
    @(negedge clk);
    chk("accept_ready", 32'(get_ir(s)), 32'd1);
    @(posedge clk);
    #1 set_in(s, 1'b0, '0, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_ov(s) && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("product", get_p(s), exp_p);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_stable", get_p(s), exp_p);
      chk("bp_in_ready", 32'(get_ir(s)), 32'd0);
      chk("bp_valid", 32'(get_ov(s)), 32'd1);
    end
    set_ordy(s, 1'b1);
    @(posedge clk);
    #1 set_ordy(s, 1'b0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    if1.flush = 1'b0; if0.flush = 1'b0;
    set_in(1, 1'b0, '0, '0); set_in(0, 1'b0, '0, '0);
    set_ordy(1, 1'b0); set_ordy(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_p", if1.out_p, 32'd0);
    chk("rst_in_ready", 32'(if1.in_ready), 32'd1);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op(1, 32'd7, 32'd6, 0, 32'd42, 4);
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 32'h0000_0003, 33);
    op(1, 32'h8000_0000, 32'd2, 0, 32'h0, 3);
    op(1, 32'h1234_5678, 32'd0, 0, 32'h0, 1);
    op(1, 32'd9, 32'd11, 5, 32'd99, 5);
    op(1, 32'd13, 32'd3, 0, 32'd39, 3);

    // Operands offered during a flush in IDLE must be ignored.
    if1.flush = 1'b1;
    set_in(1, 1'b1, 32'd1, 32'd1);
    @(negedge clk);
    chk("idle_flush_ready", 32'(if1.in_ready), 32'd0);
    @(posedge clk);
    #1 if1.flush = 1'b0;
    set_in(1, 1'b0, '0, '0);
    @(negedge clk);
    chk("idle_flush_busy", 32'(if1.busy), 32'd0);
    @(posedge clk);
    #1;

    // Flush on the tenth RUN step.
    set_in(1, 1'b1, 32'd3, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 set_in(1, 1'b0, '0, '0);
    repeat (9) @(posedge clk);
    #1 if1.flush = 1'b1;
    @(posedge clk);
    #1 if1.flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(if1.out_valid), 32'd0);
    chk("flush_busy", 32'(if1.busy), 32'd0);
    chk("flush_ready", 32'(if1.in_ready), 32'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (if1.out_valid) cnt++;
    end
    chk("flush_no_valid", 32'(cnt), 32'd0);
    @(posedge clk);
    #1 op(1, 32'd5, 32'd5, 0, 32'd25, 4);

    // Asynchronous reset in the middle of a run.
    set_in(1, 1'b1, 32'd7, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 set_in(1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if1.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(if1.busy), 32'd0);
    chk("mid_rst_ready", 32'(if1.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (if1.out_valid) cnt++;
    end
    chk("mid_rst_no_valid", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;

    // Fixed 32-step instance.
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 32'h0000_0003, 33);
    op(0, 32'd7, 32'd6, 0, 32'd42, 33);
    op(0, 32'h1234_5678, 32'd0, 0, 32'h0, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
